// File: rtl/ssdec_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment bit order is gfedcba, bit0 = a.
package ssdec_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/ssdec_scan_timer.sv
// Scan timing: prescaler, digit index, frame pulse and blink phase.
// frame_done marks the last cycle of the last digit slot.
module ssdec_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  localparam int IW = $clog2(NUM_DIGITS),
  localparam int PW = $clog2(SCAN_DIV),
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] o_idx,
  output logic          o_frame_done,
  output logic          o_phase
);

  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic          w_wrap;
  logic          w_last;

  assign w_wrap       = (r_presc == PW'(SCAN_DIV - 1));
  assign w_last       = (r_idx == IW'(NUM_DIGITS - 1));
  assign o_frame_done = w_wrap & w_last;
  assign o_idx        = r_idx;
  assign o_phase      = r_phase;

  // Prescaler and digit index advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Blink phase toggles after BLINK_FRAMES frame boundaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (o_frame_done) begin
      if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssdec_scan.sv
// Multiplexed hex display driver with tear-free frame updates.
// Loads land in a shadow copy and go live only at a frame boundary.
module ssdec_scan
  import ssdec_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    en,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [IW-1:0] w_idx;
  logic          w_phase;
  logic [VW-1:0] r_shadow;
  logic [VW-1:0] r_active;
  logic          r_pending;
  logic [3:0]    w_nib;
  logic          w_lz_blank;
  logic          w_zero_above;
  logic          w_blank;

  ssdec_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_idx       (w_idx),
    .o_frame_done(frame_done),
    .o_phase     (w_phase)
  );

  // Shadow/active update; boundary loads bypass the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) r_shadow <= value;
      if (frame_done) begin
        if (load) r_active <= value;
        else if (r_pending) r_active <= r_shadow;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Leading-zero and blink blanking for the current digit
  always_comb begin
    w_zero_above = 1'b1;
    w_lz_blank   = 1'b0;
    w_nib        = r_active[4*w_idx +: 4];
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above & (r_active[4*i +: 4] == 4'h0);
      if (i == int'(w_idx))
        w_lz_blank = w_zero_above & (i != 0);
    end
    w_blank = (lz_suppress & w_lz_blank) |
              (w_phase & blink_mask[w_idx]);
  end

  // Registered segment and digit-select outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= '0;
      dig_sel <= '0;
    end else if (!en) begin
      seg_out <= '0;
      dig_sel <= '0;
    end else begin
      seg_out <= w_blank ? SEG_BLANK : SEG_TABLE[w_nib];
      dig_sel <= NUM_DIGITS'(1) << w_idx;
    end
  end

endmodule

// File: tb/tb_ssdec_scan.sv
// Scoreboard bench for ssdec_scan with a cycle-count reference model.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_ssdec_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = N * SD;

  localparam logic [6:0] SEGT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [6:0]   seg;
    logic [N-1:0] dig;
    logic         fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [4*N-1:0] value = '0;
  logic          en = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [N-1:0]  blink_mask = '0;
  logic [6:0]    seg_out;
  logic [N-1:0]  dig_sel;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  exp_t q[$];

  // reference model state
  int unsigned    m_t = 0;
  logic [4*N-1:0] m_active = '0;
  logic [4*N-1:0] m_shadow = '0;
  logic           m_pend = 1'b0;

  // stimulus-side settings
  logic           s_en = 1'b0;
  logic           s_lz = 1'b0;
  logic [N-1:0]   s_mask = '0;

  ssdec_scan #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .en         (en),
    .lz_suppress(lz_suppress),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // one clock cycle of stimulus plus model step
  task automatic tick(input logic r, input logic ld,
                      input logic [4*N-1:0] v);
    exp_t e;
    int idx;
    logic ph, blank, bnd;
    @(negedge clk);
    rst = r;
    load = ld;
    value = v;
    en = s_en;
    lz_suppress = s_lz;
    blink_mask = s_mask;
    if (r) begin
      m_t = 0;
      m_active = '0;
      m_shadow = '0;
      m_pend = 1'b0;
      e = '0;
      q.push_back(e);
      return;
    end
    idx = (m_t / SD) % N;
    ph = ((m_t / FR) / BF) % 2 == 1;
    blank = (ph && s_mask[idx]) ||
      (s_lz && idx != 0 && (m_active >> (4 * idx)) == 0);
    e.dig = s_en ? N'(1 << idx) : '0;
    e.seg = (!s_en || blank) ? 7'h00 :
            SEGT[(m_active >> (4 * idx)) & 16'hF];
    e.fd = ((m_t + 1) % FR) == FR - 1;
    q.push_back(e);
    bnd = (m_t % FR) == FR - 1;
    if (ld && bnd) begin
      m_active = v;
      m_pend = 1'b0;
    end else if (bnd && m_pend) begin
      m_active = m_shadow;
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = v;
      m_pend = 1'b1;
    end
    m_t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
  endtask

  task automatic to_phase(input int p);
    int g = 0;
    while ((m_t % FR) != p && g < 100) begin
      tick(1'b0, 1'b0, '0);
      g++;
    end
  endtask

  // monitor: compare every post-edge sample with the queue head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (seg_out !== e.seg) begin
        fails++;
        $display("FAIL seg t=%0t got %h exp %h", $time, seg_out, e.seg);
      end
      tests++;
      if (dig_sel !== e.dig) begin
        fails++;
        $display("FAIL dig t=%0t got %b exp %b", $time, dig_sel, e.dig);
      end
      tests++;
      if (frame_done !== e.fd) begin
        fails++;
        $display("FAIL fd t=%0t got %b exp %b", $time, frame_done, e.fd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    s_en = 1'b1;
    // basic pattern
    tick(1'b0, 1'b1, 16'h12AF);
    run(3 * FR);
    // double load mid-frame
    to_phase(2);
    tick(1'b0, 1'b1, 16'h1111);
    run(FR);
    to_phase(3);
    tick(1'b0, 1'b1, 16'h3333);
    run(4);
    tick(1'b0, 1'b1, 16'h2222);
    run(2 * FR);
    // leading-zero blanking
    s_lz = 1'b1;
    tick(1'b0, 1'b1, 16'h0005);
    run(2 * FR);
    tick(1'b0, 1'b1, 16'h0000);
    run(2 * FR);
    tick(1'b0, 1'b1, 16'h0300);
    run(2 * FR);
    s_lz = 1'b0;
    // blink
    s_mask = 4'b0100;
    tick(1'b0, 1'b1, 16'h8888);
    run(5 * FR);
    s_mask = '0;
    // load on the boundary cycle
    to_phase(FR - 1);
    tick(1'b0, 1'b1, 16'hC0DE);
    run(2 * FR);
    // reset mid-frame with a pending load
    to_phase(5);
    tick(1'b0, 1'b1, 16'hBEEF);
    run(2);
    tick(1'b1, 1'b0, '0);
    run(2 * FR);
    // display disabled
    s_en = 1'b0;
    tick(1'b0, 1'b1, 16'h4567);
    run(3 * FR);
    s_en = 1'b1;
    run(FR);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ld;
      if ($urandom_range(0, 63) == 0) begin
        s_lz = 1'($urandom);
        s_mask = N'($urandom);
      end
      if ($urandom_range(0, 31) == 0) s_en = ~s_en;
      r = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 9) == 0);
      tick(r, ld, ($urandom_range(0, 3) == 0) ?
           16'($urandom_range(0, 255)) : 16'($urandom));
    end
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d left exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssdec_scan.md
SSDEC_SCAN -- requirements
Module: ssdec_scan

Interface
REQ-001 The module SHALL take parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (range 2..8).
REQ-002 The module SHALL take parameter SCAN_DIV, default 1000, meaning clock cycles each digit is held (at least 2).
REQ-003 The module SHALL take parameter BLINK_FRAMES, default 64, meaning full scan frames per blink half-period (at least 1).
REQ-004 The module SHALL have a port clk, input, 1 bit: the single system clock; all state is rising-edge.
REQ-005 The module SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have a port load, input, 1 bit: single-cycle strobe that captures value.
REQ-007 The module SHALL have a port value, input, 4*NUM_DIGITS bits: hex nibbles, with nibble i driving digit i and digit 0 least significant.
REQ-008 The module SHALL have a port en, input, 1 bit: display enable.
REQ-009 The module SHALL have a port lz_suppress, input, 1 bit: leading-zero blanking enable.
REQ-010 The module SHALL have a port blink_mask, input, NUM_DIGITS bits: digits subject to blinking.
REQ-011 The module SHALL have a port seg_out, output, 7 bits: active-high segments gfedcba, with bit0 = a.
REQ-012 The module SHALL have a port dig_sel, output, NUM_DIGITS bits: one-hot active-high digit select.
REQ-013 The module SHALL have a port frame_done, output, 1 bit: one-cycle pulse on the last cycle of digit NUM_DIGITS-1.

Function
REQ-014 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index idx SHALL advance on the prescaler wrap, wrapping from NUM_DIGITS-1 to 0.
REQ-015 A frame boundary SHALL be the cycle with idx = NUM_DIGITS-1 and prescaler = SCAN_DIV-1; frame_done SHALL be asserted combinationally from registered state in exactly that cycle.
REQ-016 On load, value SHALL be written to a shadow register and a pending flag SHALL be set.
REQ-017 At a frame boundary with pending set, shadow SHALL be copied to the active register and pending SHALL be cleared.
REQ-018 A load coinciding with a frame boundary SHALL be copied directly to active (value bypasses shadow), and pending SHALL end cleared.
REQ-019 Repeated loads within one frame SHALL keep only the last value; the display SHALL never change mid-frame (no tearing).
REQ-020 Segment encoding 0..F SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-021 seg_out and dig_sel SHALL be registered, reflecting idx with one cycle latency.
REQ-022 Leading-zero blanking: with lz_suppress=1, digit i SHALL be blanked if active nibbles NUM_DIGITS-1 down to i are all zero; digit 0 SHALL never be blanked by this rule.
REQ-023 A blink phase bit SHALL toggle every BLINK_FRAMES frame boundaries; while it is 1, digits with blink_mask[i]=1 SHALL be blanked.
REQ-024 A blanked digit SHALL drive seg_out=0 with dig_sel still one-hot.
REQ-025 With en=0, seg_out and dig_sel SHALL be 0; the prescaler, idx, blink phase and load capture SHALL continue running unchanged.
REQ-026 frame_done SHALL be independent of en.

Reset
REQ-027 On rst, the prescaler, idx, blink phase, shadow, active, pending, seg_out and dig_sel SHALL all be cleared to 0, and frame_done SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL discard any pending load; the first cycle after release SHALL start digit 0 at prescaler 0.

Structure
REQ-029 Package ssdec_pkg SHALL hold the 16-entry segment table constant and the blank-pattern constant.
REQ-030 Sub-module ssdec_scan_timer SHALL contain the prescaler, idx, frame_done and blink phase; decode, blanking and update logic SHALL stay in the top.
REQ-031 Counter widths SHALL be derived with $clog2 of the corresponding parameter.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-032 Load 16'h12AF, en=1 -> after the next frame boundary, each 4-cycle slot shows dig_sel 0001/0010/0100/1000 with seg 71/77/5B/06.
REQ-033 Load 16'h1111, then 16'h2222 mid-frame -> the current frame shows its old value, and the next frame shows all 5B (never 06).
REQ-034 lz_suppress=1, load 16'h0005 -> digits 3..1 show seg 00 and digit 0 shows 6D; load 16'h0000 -> digit 0 shows 3F.
REQ-035 blink_mask=4'b0100, value 16'h8888 -> digit 2 shows 7F for 2 frames, then 00 for 2 frames, repeating; other digits stay at 7F.
REQ-036 Load at a frame-boundary cycle -> the new value is shown from the following frame; rst pulsed mid-frame with pending set -> outputs 0 and no update on the next frame.
REQ-037 en=0 for 3 frames -> seg_out and dig_sel are 0 while frame_done still pulses every 16 cycles.
